// File: rtl/mont_reduce_serial.sv
// Digit-serial Montgomery reduction r = T * 2^(-N) mod m, one W-bit quotient digit per clock.
// Define MONT_FINAL_SUB_EN to add the final conditional subtract (r_out < m); otherwise r_out < 2m.
module mont_reduce_serial #(
    parameter int N = 3072,
    parameter int W = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] t_in,
    input  logic [N-1:0]   m,
    input  logic [W-1:0]   m_prime,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N:0]     r_out,
    output logic           busy
);

    localparam int DIGITS = N / W;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    generate
        if (N % W != 0) begin : g_bad_width
            $error("mont_reduce_serial: N must be a multiple of W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FSUB = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [2*N:0]    acc;
    logic [N-1:0]    m_r;
    logic [W-1:0]    mp_r;
    logic [CW-1:0]   cnt;
    logic [N:0]      r;

    logic [W-1:0]    q;
    logic [N+W-1:0]  qm;
    logic [2*N:0]    sum;
    logic [2*N:0]    acc_next;
    logic            last;

    // q is chosen so that the low digit of acc + q*m is zero; the shift drops it exactly.
    always_comb begin
        q        = acc[W-1:0] * mp_r;
        qm       = (N+W)'(q) * (N+W)'(m_r);
        sum      = acc + (2*N+1)'(qm);
        acc_next = sum >> W;
        last     = (cnt == CW'(DIGITS - 1));
    end

    always_comb begin
        state_next = state;
        in_ready   = (state == IDLE);
        out_valid  = (state == DONE);
        busy       = (state != IDLE);
        r_out      = r;
        case (state)
            IDLE: if (in_valid) state_next = ITER;
            ITER: if (last) begin
`ifdef MONT_FINAL_SUB_EN
                state_next = FSUB;
`else
                state_next = DONE;
`endif
            end
            FSUB: state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            m_r  <= '0;
            mp_r <= '0;
            cnt  <= '0;
            r    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    acc  <= {1'b0, t_in};
                    m_r  <= m;
                    mp_r <= m_prime;
                    cnt  <= '0;
                    r    <= '0;
                end
                ITER: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
`ifndef MONT_FINAL_SUB_EN
                    // lazy form: the last partial result is already bounded by 2m
                    if (last) r <= acc_next[N:0];
`endif
                end
                FSUB: begin
                    if (acc[N:0] >= {1'b0, m_r}) r <= acc[N:0] - {1'b0, m_r};
                    else                         r <= acc[N:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_reduce_serial.sv
// Directed bench for mont_reduce_serial at N=16/W=4 plus a randomized N=3072/W=64 run
// against a radix-2 reference reduction.
module tb_mont_reduce_serial;

    localparam int SN = 16;
    localparam int SW = 4;
    localparam int BN = 3072;
    localparam int BW = 64;
`ifdef MONT_FINAL_SUB_EN
    localparam int FS = 1;
`else
    localparam int FS = 0;
`endif
    localparam int LAT = SN / SW + 1 + FS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
    logic [2*SN-1:0] s_t;
    logic [SN-1:0]   s_m;
    logic [SW-1:0]   s_mp;
    logic [SN:0]     s_r;

    logic            b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [2*BN-1:0] b_t;
    logic [BN-1:0]   b_m;
    logic [BW-1:0]   b_mp;
    logic [BN:0]     b_r;

    mont_reduce_serial #(.N(SN), .W(SW)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .t_in(s_t), .m(s_m), .m_prime(s_mp), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .r_out(s_r), .busy(s_busy)
    );

    mont_reduce_serial #(.N(BN), .W(BW)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .t_in(b_t), .m(b_m), .m_prime(b_mp), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .r_out(b_r), .busy(b_busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] t;
        logic [16:0] r_sub;
        logic [16:0] r_lazy;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic start_small(input logic [31:0] t);
        @(posedge clk); #1;
        s_m = 16'hFFF1; s_mp = 4'hF; s_t = t; s_in_valid = 1'b1;
        @(posedge clk); #1;
        // inputs are free to change once accepted
        s_in_valid = 1'b0; s_t = 32'hDEAD_BEEF; s_m = 16'h1235; s_mp = 4'h3;
    endtask

    task automatic run_small(input string name, input logic [31:0] t, input logic [16:0] exp_r);
        int lat;
        bit rdy_seen;
        start_small(t);
        lat = 1; rdy_seen = 0;
        while (!s_out_valid && lat < 40) begin
            if (s_in_ready) rdy_seen = 1;
            @(posedge clk); #1;
            lat++;
        end
        chk({name, " latency"}, 64'(lat), 64'(LAT));
        chk({name, " r_out"}, 64'(s_r), 64'(exp_r));
        chk({name, " in_ready during job"}, 64'(rdy_seen | s_in_ready), 64'd0);
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        chk({name, " in_ready after"}, 64'(s_in_ready), 64'd1);
        chk({name, " out_valid after"}, 64'(s_out_valid), 64'd0);
    endtask

    function automatic logic [BN:0] gold(input logic [2*BN-1:0] t, input logic [BN-1:0] mm);
        logic [2*BN:0] a;
        a = {1'b0, t};
        for (int i = 0; i < BN; i++) begin
            if (a[0]) a = a + (2*BN+1)'(mm);
            a = a >> 1;
        end
        if (a[BN:0] >= {1'b0, mm}) a = a - (2*BN+1)'(mm);
        return a[BN:0];
    endfunction

    logic [BN-1:0] rm, thi;
    logic [BN-1:0] tlo;
    logic [BW-1:0] inv;
    logic [BN:0]   exp_b;

    initial begin
        vecs[0] = '{32'h0000_0000, 17'h00000, 17'h00000};
        vecs[1] = '{32'h0000_FFF1, 17'h00000, 17'h0FFF1};
        vecs[2] = '{32'h0005_0000, 17'h00005, 17'h00005};
        vecs[3] = '{32'h0001_0000, 17'h00001, 17'h00001};
        vecs[4] = '{32'h0000_0001, 17'h0EEE1, 17'h0EEE1};
        vecs[5] = '{32'h0000_FFFF, 17'h01111, 17'h01111};
        vecs[6] = '{32'hFFF0_FFFF, 17'h01110, 17'h11101};
        vecs[7] = '{32'hFFF0_0000, 17'h0FFF0, 17'h0FFF0};

        rst = 1'b1;
        s_in_valid = 0; s_out_ready = 0; s_t = '0; s_m = '0; s_mp = '0;
        b_in_valid = 0; b_out_ready = 0; b_t = '0; b_m = '0; b_mp = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(s_in_ready), 64'd1);
        chk("reset out_valid", 64'(s_out_valid), 64'd0);
        chk("reset busy", 64'(s_busy), 64'd0);
        chk("reset r_out", 64'(s_r), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_small($sformatf("vec%0d", i), vecs[i].t, FS ? vecs[i].r_sub : vecs[i].r_lazy);

        // consumer stalls in DONE; in_valid pulses must not disturb the held result
        start_small(32'h0005_0000);
        for (int k = 0; k < 40 && !s_out_valid; k++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 10; i++) begin
            s_in_valid = 1'(i & 1); s_t = 32'h0000_0001;
            chk($sformatf("stall%0d out_valid", i), 64'(s_out_valid), 64'd1);
            chk($sformatf("stall%0d r_out", i), 64'(s_r), 64'h5);
            chk($sformatf("stall%0d in_ready", i), 64'(s_in_ready), 64'd0);
            @(posedge clk); #1;
        end
        s_in_valid = 1'b1; s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0; s_out_ready = 1'b0;
        chk("release in_ready", 64'(s_in_ready), 64'd1);
        chk("release busy", 64'(s_busy), 64'd0);
        @(posedge clk); #1;
        chk("release no accept", 64'(s_busy), 64'd0);

        // reset in the middle of ITER abandons the job
        start_small(32'h0005_0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst in_ready", 64'(s_in_ready), 64'd1);
        chk("midrst out_valid", 64'(s_out_valid), 64'd0);
        chk("midrst busy", 64'(s_busy), 64'd0);
        chk("midrst r_out", 64'(s_r), 64'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("midrst stays idle", 64'(s_out_valid | s_busy), 64'd0);
        run_small("after rst", 32'h0005_0000, 17'h00005);

        for (int j = 0; j < 200; j++) begin
            int w;
            for (int k = 0; k < BN / 32; k++) begin
                rm[k*32 +: 32]  = $urandom();
                thi[k*32 +: 32] = $urandom();
                tlo[k*32 +: 32] = $urandom();
            end
            rm[BN-1] = 1'b1; rm[0] = 1'b1;
            thi = thi % rm;
            inv = rm[BW-1:0];
            repeat (6) inv = inv * (64'd2 - rm[BW-1:0] * inv);
            exp_b = gold({thi, tlo}, rm);
            @(posedge clk); #1;
            b_t = {thi, tlo}; b_m = rm; b_mp = -inv; b_in_valid = 1'b1;
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            w = 0;
            while (!b_out_valid && w < 200) begin
                @(posedge clk); #1;
                w++;
            end
            checks++;
            if (!b_out_valid || !(b_r == exp_b || (FS == 0 && b_r == exp_b + {1'b0, rm}))) begin
                errors++;
                $display("FAIL big%0d: got low %0h valid %0b expected low %0h", j,
                         b_r[63:0], b_out_valid, exp_b[63:0]);
            end
            b_out_ready = 1'b1;
            @(posedge clk); #1;
            b_out_ready = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
